// File: rtl/i2c_slave_regfile.sv
// I2C slave register file: master writes land in rx_regs with an auto-incrementing pointer.
// Define I2C_SLV_READ_EN to serve master reads from tx_regs; otherwise read addresses are NACKed.
module i2c_slave_regfile #(
   parameter logic [6:0]  SLAVE_ADDR = 7'h55,
   parameter int unsigned NUM_REGS   = 6,
   parameter int unsigned PTR_W      = $clog2(NUM_REGS + 1)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  scl,
   inout  wire                   sda,
   output logic [8*NUM_REGS-1:0] rx_regs,
   output logic [PTR_W-1:0]      rx_count,
   output logic                  rx_done,
   input  logic                  done_ack,
   input  logic [8*NUM_REGS-1:0] tx_regs,
   output logic                  busy
);

   localparam int unsigned BCNT_W = 4;

   typedef enum logic [2:0] {
      S_IDLE, S_ADDR, S_ADDR_ACK, S_WR_DATA, S_WR_ACK, S_RD_DATA, S_RD_ACK, S_DONE
   } state_t;

   state_t                  state_q, state_d;
   logic [BCNT_W-1:0]       bit_cnt_q, bit_cnt_d;
   logic [7:0]              shift_q, shift_d;
   logic [PTR_W-1:0]        ptr_q, ptr_d;
   logic                    rw_q, rw_d;
   logic                    rd_ack_q, rd_ack_d;
   logic                    sda_oe_q, sda_oe_d;
   logic [8*NUM_REGS-1:0]   rx_regs_q, rx_regs_d;
   logic [PTR_W-1:0]        rx_count_q, rx_count_d;
   logic                    rx_done_q, rx_done_d;
   logic                    busy_q, busy_d;

   logic scl_meta_q, scl_sync_q, scl_prev_q;
   logic sda_meta_q, sda_sync_q, sda_prev_q;
   logic scl_rise_c, scl_fall_c, start_c, stop_c;

   // Two-flop synchronizers plus one delayed copy for edge detection
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         scl_meta_q <= 1'b1;
         scl_sync_q <= 1'b1;
         scl_prev_q <= 1'b1;
         sda_meta_q <= 1'b1;
         sda_sync_q <= 1'b1;
         sda_prev_q <= 1'b1;
      end else begin
         scl_meta_q <= scl;
         scl_sync_q <= scl_meta_q;
         scl_prev_q <= scl_sync_q;
         sda_meta_q <= sda;
         sda_sync_q <= sda_meta_q;
         sda_prev_q <= sda_sync_q;
      end
   end

   assign scl_rise_c = scl_sync_q & ~scl_prev_q;
   assign scl_fall_c = ~scl_sync_q & scl_prev_q;
   assign start_c    = scl_sync_q & scl_prev_q & sda_prev_q & ~sda_sync_q;
   assign stop_c     = scl_sync_q & scl_prev_q & ~sda_prev_q & sda_sync_q;

`ifdef I2C_SLV_READ_EN
   logic [PTR_W-1:0] ptr_inc_c, tx_idx_c;
   logic [7:0]       tx_byte_c;

   // Byte to load into the shifter when (re)entering RD_DATA
   always_comb begin
      ptr_inc_c = (ptr_q == PTR_W'(NUM_REGS - 1)) ? '0 : ptr_q + PTR_W'(1);
      tx_idx_c  = (state_q == S_RD_ACK) ? ptr_inc_c : ptr_q;
      tx_byte_c = '0;
      for (int i = 0; i < int'(NUM_REGS); i++) begin
         if (tx_idx_c == PTR_W'(i)) tx_byte_c = tx_regs[8*i +: 8];
      end
   end
`else
   logic unused_tx_c;
   assign unused_tx_c = ^tx_regs;
`endif

   // Next-state and datapath; sda drive only changes on a synchronized scl fall
   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      ptr_d      = ptr_q;
      rw_d       = rw_q;
      rd_ack_d   = rd_ack_q;
      sda_oe_d   = sda_oe_q;
      rx_regs_d  = rx_regs_q;
      rx_count_d = rx_count_q;
      rx_done_d  = rx_done_q;

      if (state_q == S_DONE) begin
         if (done_ack) begin
            state_d   = S_IDLE;
            rx_done_d = 1'b0;
         end
      end else if (start_c) begin
         state_d   = S_ADDR;
         bit_cnt_d = '0;
         ptr_d     = '0;
         sda_oe_d  = 1'b0;
      end else if (stop_c) begin
         bit_cnt_d = '0;
         sda_oe_d  = 1'b0;
         if (state_q != S_IDLE && !rw_q && ptr_q != '0) begin
            rx_count_d = ptr_q;
            rx_done_d  = 1'b1;
            state_d    = S_DONE;
         end else begin
            state_d = S_IDLE;
            ptr_d   = '0;
         end
      end else begin
         case (state_q)
            S_ADDR: begin
               if (scl_rise_c) begin
                  shift_d   = {shift_q[6:0], sda_sync_q};
                  bit_cnt_d = bit_cnt_q + BCNT_W'(1);
               end else if (scl_fall_c && bit_cnt_q == BCNT_W'(8)) begin
                  bit_cnt_d = '0;
                  rw_d      = shift_q[0];
                  if (shift_q[7:1] == SLAVE_ADDR) begin
                     state_d = S_ADDR_ACK;
`ifdef I2C_SLV_READ_EN
                     sda_oe_d = 1'b1;
`else
                     sda_oe_d = ~shift_q[0];
`endif
                  end else begin
                     state_d = S_IDLE;
                  end
               end
            end
            S_ADDR_ACK: begin
               if (scl_fall_c) begin
                  sda_oe_d  = 1'b0;
                  bit_cnt_d = '0;
                  if (!rw_q) begin
                     state_d = S_WR_DATA;
                  end else begin
`ifdef I2C_SLV_READ_EN
                     state_d  = S_RD_DATA;
                     shift_d  = tx_byte_c;
                     sda_oe_d = ~tx_byte_c[7];
`else
                     state_d = S_IDLE;
`endif
                  end
               end
            end
            S_WR_DATA: begin
               if (scl_rise_c) begin
                  shift_d   = {shift_q[6:0], sda_sync_q};
                  bit_cnt_d = bit_cnt_q + BCNT_W'(1);
               end else if (scl_fall_c && bit_cnt_q == BCNT_W'(8)) begin
                  bit_cnt_d = '0;
                  state_d   = S_WR_ACK;
                  if (ptr_q < PTR_W'(NUM_REGS)) begin
                     for (int i = 0; i < int'(NUM_REGS); i++) begin
                        if (ptr_q == PTR_W'(i)) rx_regs_d[8*i +: 8] = shift_q;
                     end
                     ptr_d    = ptr_q + PTR_W'(1);
                     sda_oe_d = 1'b1;
                  end
               end
            end
            S_WR_ACK: begin
               if (scl_fall_c) begin
                  sda_oe_d = 1'b0;
                  state_d  = S_WR_DATA;
               end
            end
`ifdef I2C_SLV_READ_EN
            S_RD_DATA: begin
               if (scl_rise_c) begin
                  bit_cnt_d = bit_cnt_q + BCNT_W'(1);
               end else if (scl_fall_c) begin
                  if (bit_cnt_q == BCNT_W'(8)) begin
                     bit_cnt_d = '0;
                     sda_oe_d  = 1'b0;
                     rd_ack_d  = 1'b0;
                     state_d   = S_RD_ACK;
                  end else begin
                     shift_d  = {shift_q[6:0], 1'b0};
                     sda_oe_d = ~shift_q[6];
                  end
               end
            end
            // A NACKed byte leaves us here until STOP or START
            S_RD_ACK: begin
               if (scl_rise_c) begin
                  rd_ack_d = ~sda_sync_q;
               end else if (scl_fall_c && rd_ack_q) begin
                  ptr_d     = ptr_inc_c;
                  shift_d   = tx_byte_c;
                  sda_oe_d  = ~tx_byte_c[7];
                  bit_cnt_d = '0;
                  state_d   = S_RD_DATA;
               end
            end
`endif
            default: ;
         endcase
      end

      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= S_IDLE;
         bit_cnt_q  <= '0;
         shift_q    <= '0;
         ptr_q      <= '0;
         rw_q       <= 1'b0;
         rd_ack_q   <= 1'b0;
         sda_oe_q   <= 1'b0;
         rx_regs_q  <= '0;
         rx_count_q <= '0;
         rx_done_q  <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         ptr_q      <= ptr_d;
         rw_q       <= rw_d;
         rd_ack_q   <= rd_ack_d;
         sda_oe_q   <= sda_oe_d;
         rx_regs_q  <= rx_regs_d;
         rx_count_q <= rx_count_d;
         rx_done_q  <= rx_done_d;
         busy_q     <= busy_d;
      end
   end

   assign sda      = sda_oe_q ? 1'b0 : 1'bz;
   assign rx_regs  = rx_regs_q;
   assign rx_count = rx_count_q;
   assign rx_done  = rx_done_q;
   assign busy     = busy_q;

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Directed bench for i2c_slave_regfile: behavioural I2C master on an open-drain sda with pull-up.
`timescale 1ns/1ps
module tb_i2c_slave_regfile;

   localparam int unsigned NUM_REGS = 6;
   localparam int unsigned PTR_W    = 3;
   localparam int unsigned Q        = 100;   // quarter SCL period, 10 clk

   logic                  clk = 1'b0;
   logic                  reset;
   logic                  scl;
   logic                  m_sda_oe;
   logic                  done_ack;
   wire                   sda;
   logic [8*NUM_REGS-1:0] rx_regs;
   logic [8*NUM_REGS-1:0] tx_regs;
   logic [PTR_W-1:0]      rx_count;
   logic                  rx_done;
   logic                  busy;

   int   n_checks = 0;
   int   n_pass   = 0;
   logic low_mon  = 1'b0;
   logic low_seen;
   logic ack;
   logic [7:0] rd;

   pullup (sda);
   assign sda = m_sda_oe ? 1'b0 : 1'bz;

   always #5 clk = ~clk;

   i2c_slave_regfile #(.SLAVE_ADDR(7'h55), .NUM_REGS(NUM_REGS), .PTR_W(PTR_W)) dut (
      .clk      (clk),
      .reset    (reset),
      .scl      (scl),
      .sda      (sda),
      .rx_regs  (rx_regs),
      .rx_count (rx_count),
      .rx_done  (rx_done),
      .done_ack (done_ack),
      .tx_regs  (tx_regs),
      .busy     (busy)
   );

   // Flags any low on sda while the master itself is releasing it
   always @(posedge clk) begin
      if (!low_mon) low_seen <= 1'b0;
      else if (!m_sda_oe && sda === 1'b0) low_seen <= 1'b1;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic m_start();
      m_sda_oe = 1'b0; #(Q);
      scl = 1'b1;      #(Q);
      m_sda_oe = 1'b1; #(Q);
      scl = 1'b0;      #(Q);
   endtask

   task automatic m_stop();
      m_sda_oe = 1'b1; #(Q);
      scl = 1'b1;      #(Q);
      m_sda_oe = 1'b0; #(Q);
   endtask

   task automatic m_bit(input logic b);
      m_sda_oe = ~b; #(Q);
      scl = 1'b1;    #(2*Q);
      scl = 1'b0;    #(Q);
   endtask

   task automatic m_read_bit(output logic b);
      m_sda_oe = 1'b0; #(Q);
      scl = 1'b1;      #(Q);
      b = (sda !== 1'b0);
      #(Q);
      scl = 1'b0;      #(Q);
   endtask

   task automatic m_write(input logic [7:0] d, output logic a);
      logic b;
      for (int i = 7; i >= 0; i--) m_bit(d[i]);
      m_read_bit(b);
      a = ~b;
   endtask

   task automatic m_read(output logic [7:0] d, input logic give_ack);
      logic b;
      for (int i = 7; i >= 0; i--) begin
         m_read_bit(b);
         d[i] = b;
      end
      m_bit(~give_ack);
   endtask

   task automatic pulse_done_ack();
      @(negedge clk) done_ack = 1'b1;
      @(negedge clk);
      @(negedge clk) done_ack = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   initial begin
      reset    = 1'b1;
      scl      = 1'b1;
      m_sda_oe = 1'b0;
      done_ack = 1'b0;
      tx_regs  = {32'h0, 8'h5A, 8'hC3};
      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (5) @(negedge clk);

      check("rst_rx_regs", 64'(rx_regs), 64'h0);
      check("rst_rx_count", 64'(rx_count), 64'h0);
      check("rst_rx_done", 64'(rx_done), 64'h0);
      check("rst_busy", 64'(busy), 64'h0);
      check("rst_sda", 64'(sda), 64'h1);

      // Six-byte write
      m_start();
      check("wr1_busy", 64'(busy), 64'h1);
      m_write(8'hAA, ack);
      check("wr1_addr_ack", 64'(ack), 64'h1);
      for (int i = 0; i < 6; i++) begin
         m_write(8'(8'h11 * (i + 1)), ack);
         check($sformatf("wr1_ack%0d", i), 64'(ack), 64'h1);
      end
      m_stop();
      repeat (5) @(negedge clk);
      check("wr1_regs", 64'(rx_regs), 64'h665544332211);
      check("wr1_count", 64'(rx_count), 64'h6);
      check("wr1_done", 64'(rx_done), 64'h1);
      repeat (20) @(negedge clk);
      check("wr1_done_held", 64'(rx_done), 64'h1);
      pulse_done_ack();
      check("wr1_done_clr", 64'(rx_done), 64'h0);
      check("wr1_idle", 64'(busy), 64'h0);

      // Address mismatch: slave must stay off the bus
      low_mon = 1'b1;
      m_start();
      m_write(8'h54, ack);
      check("mis_addr_ack", 64'(ack), 64'h0);
      m_write(8'h99, ack);
      m_stop();
      repeat (5) @(negedge clk);
      check("mis_no_drive", 64'(low_seen), 64'h0);
      low_mon = 1'b0;
      check("mis_regs", 64'(rx_regs), 64'h665544332211);
      check("mis_done", 64'(rx_done), 64'h0);
      check("mis_busy", 64'(busy), 64'h0);

      // Seven bytes into six registers: last one NACKed
      m_start();
      m_write(8'hAA, ack);
      for (int i = 0; i < 7; i++) begin
         m_write(8'(8'hA1 + i), ack);
         check($sformatf("ovf_ack%0d", i), 64'(ack), (i < 6) ? 64'h1 : 64'h0);
      end
      m_stop();
      repeat (5) @(negedge clk);
      check("ovf_regs", 64'(rx_regs), 64'hA6A5A4A3A2A1);
      check("ovf_count", 64'(rx_count), 64'h6);
      check("ovf_done", 64'(rx_done), 64'h1);
      pulse_done_ack();

      // Repeated START restarts the pointer
      m_start();
      m_write(8'hAA, ack);
      m_write(8'hB1, ack);
      m_write(8'hB2, ack);
      m_start();
      check("rs_no_done", 64'(rx_done), 64'h0);
      m_write(8'hAA, ack);
      check("rs_addr_ack", 64'(ack), 64'h1);
      m_write(8'h77, ack);
      m_stop();
      repeat (5) @(negedge clk);
      check("rs_regs", 64'(rx_regs), 64'hA6A5A4A3B277);
      check("rs_count", 64'(rx_count), 64'h1);
      check("rs_done", 64'(rx_done), 64'h1);
      pulse_done_ack();

      // Read transaction
      m_start();
      m_write(8'hAB, ack);
`ifdef I2C_SLV_READ_EN
      check("rd_addr_ack", 64'(ack), 64'h1);
      m_read(rd, 1'b1);
      check("rd_byte0", 64'(rd), 64'hC3);
      m_read(rd, 1'b0);
      check("rd_byte1", 64'(rd), 64'h5A);
`else
      check("rd_addr_nack", 64'(ack), 64'h0);
`endif
      m_stop();
      repeat (5) @(negedge clk);
      check("rd_done", 64'(rx_done), 64'h0);
      check("rd_busy", 64'(busy), 64'h0);
      check("rd_regs", 64'(rx_regs), 64'hA6A5A4A3B277);

      // Reset while the slave is driving an ACK
      m_start();
      m_write(8'hAA, ack);
      for (int i = 7; i >= 0; i--) m_bit(1'(8'h12 >> i));
      m_sda_oe = 1'b0;
      #1;
      check("ra_ack_drive", 64'(sda), 64'h0);
      check("ra_byte0", 64'(rx_regs[7:0]), 64'h12);
      reset = 1'b1;
      #1;
      check("ra_sda_rel", 64'(sda), 64'h1);
      check("ra_regs", 64'(rx_regs), 64'h0);
      check("ra_count", 64'(rx_count), 64'h0);
      check("ra_done", 64'(rx_done), 64'h0);
      check("ra_busy", 64'(busy), 64'h0);
      scl = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (5) @(negedge clk);
      check("ra_post_sda", 64'(sda), 64'h1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/i2c_slave_regfile.md
# i2c_slave_regfile

Parametrised I2C slave register file for inter-board links between player boards. It receives writes from a remote I2C master into NUM_REGS byte registers with an auto-incrementing pointer, and optionally serves master reads from a local transmit bank. It raises a level-held completion flag after each STOP-terminated write transaction and holds it until the local consumer acknowledges.

## Interface
- SLAVE_ADDR, 7'h55: 7-bit device address matched in the address phase.
- NUM_REGS, 6: number of 8-bit receive registers, 1..16. Also the number of transmit bytes.
- PTR_W, $clog2(NUM_REGS+1): width of the pointer and of rx_count.

- clk  in  1  system clock, at least 20× SCL frequency.
- reset  in  1  asynchronous, active-high.
- scl  in  1  I2C clock from the master; the block never drives it.
- sda  inout  1  open-drain data line. The block drives only 0 or Z.
- rx_regs  out  8*NUM_REGS  receive registers; byte i occupies bits [8i+7:8i].
- rx_count  out  PTR_W  bytes accepted in the last completed write.
- rx_done  out  1  write transaction complete; level signal, held until done_ack.
- done_ack  in  1  consumer acknowledge; clears rx_done.
- tx_regs  in  8*NUM_REGS  read bank; sampled per byte at load time.
- busy  out  1  high from START until return to IDLE.

## Operation
- scl and sda each pass through a 2-flop synchronizer, reset value 1. Edges are detected on the synchronized copies.
- START: sda falls while scl is high. STOP: sda rises while scl is high. Both are detected in every state except DONE.
- A START in any non-DONE state, including a repeated START, does the following:
  - resets the bit counter and the pointer;
  - goes to ADDR;
  - sets busy.
- States and transitions:
  - IDLE: on START → ADDR.
  - ADDR: shift sda in on each scl rise. After the 8th scl fall:
    - address match → ADDR_ACK;
    - no match → IDLE, with sda never driven.
  - ADDR_ACK: drive sda=0 for one SCL period. On scl fall:
    - R/W=0 → WR_DATA;
    - R/W=1 → RD_DATA.
  - WR_DATA: shift 8 bits in. On the 8th scl fall:
    - ptr<NUM_REGS: write the byte to rx_regs[ptr], increment ptr, → WR_ACK;
    - ptr=NUM_REGS: discard the byte and leave sda released (NACK), → WR_ACK.
  - WR_ACK: drive the ACK only if the byte was accepted. On scl fall → WR_DATA.
  - RD_DATA: described under Configuration.
  - RD_ACK: described under Configuration.
  - STOP from any active state:
    - if ptr>0 after a write: latch rx_count=ptr, set rx_done, → DONE;
    - otherwise → IDLE.
  - DONE: holds rx_done=1 and ignores the bus. When done_ack=1 → IDLE on the next clk and clear rx_done.
- A partial byte interrupted by STOP or START is discarded. The pointer does not advance.
- rx_regs retain their values across transactions; only accepted bytes overwrite them.

## Timing
- Reset values:
  - rx_regs all 0; rx_count 0; rx_done 0; busy 0;
  - sda released (Z); state IDLE; pointer 0.
- Bus event to internal response is 2–3 clk (synchronizer latency plus one edge-detect cycle).
- sda drive changes are made only on a synchronized scl fall. They are never made while scl is high, so the block cannot produce a false START or STOP.
- rx_regs[ptr] updates on the clk that detects the 8th scl fall of the byte.
- rx_done rises 3 clk after the STOP edge on the pins.
- A done_ack that is already high when DONE is entered clears rx_done after 1 cycle.
- Reset asserted mid-byte returns to IDLE immediately and releases sda in the same cycle.

## Configuration
- I2C_SLV_READ_EN defined (read support present):
  - RD_DATA loads tx_regs[ptr] when it is entered and drives its MSB first. A 1 bit releases sda; a 0 bit drives 0.
  - After 8 bits → RD_ACK, with sda released. The master's ACK is sampled on scl rise:
    - ACK: increment ptr, wrapping to 0 after NUM_REGS-1, → RD_DATA;
    - NACK: wait for STOP or START.
  - A read transaction never sets rx_done.
- I2C_SLV_READ_EN undefined:
  - an address match with R/W=1 is NACKed (sda released in ADDR_ACK) and the block goes to IDLE;
  - the tx_regs port exists but is unused.

## Test plan
- Write 0xAA with 6 bytes 0x11..0x66 then STOP → rx_regs = 66_55_44_33_22_11; rx_count=6; rx_done=1 until done_ack, then IDLE.
- Address 0x2A (mismatch) followed by data → sda never driven low; rx_regs unchanged; rx_done stays 0.
- Write 7 bytes with NUM_REGS=6 → bytes 1–6 ACKed; the 7th NACKed and discarded; rx_count=6.
- Write 2 bytes, repeated START, write 1 byte 0x77, STOP → rx_regs[0]=0x77; rx_regs[1] keeps the old value; rx_count=1.
- With I2C_SLV_READ_EN and tx_regs byte0=0xC3, byte1=0x5A: read 2 bytes, ACK then NACK → master sees 0xC3, 0x5A; rx_done stays 0. Without the macro the same read gets NACK on the address.
- Assert reset while the slave drives an ACK → sda goes to Z within 1 clk; all outputs return to reset values.
